// File: rtl/gpr_sb_if.sv
// gpr_sb_if: bundle between the issue/decode/writeback side and the
// register file + scoreboard (gpr_sb).
//   flush         : pipeline flush toward the scoreboard
//   issue claim   : i_iss_valid / o_iss_ready / i_iss_rdid / i_iss_rdwen
//   read port 1/2 : i_rsNid -> o_rsN, o_rsN_busy
//   writeback     : i_wbu_rdid / i_wbu_rdwen / i_wbu_rd
//   status        : o_sb_empty, o_sb_err
// Signal prefixes are from the point of view of gpr_sb (slave modport).
interface gpr_sb_if #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5
);
    logic                 i_flush;
    logic                 i_iss_valid;
    logic                 o_iss_ready;
    logic [REG_ADDRW-1:0] i_iss_rdid;
    logic                 i_iss_rdwen;
    logic [REG_ADDRW-1:0] i_rs1id;
    logic [CPU_WIDTH-1:0] o_rs1;
    logic                 o_rs1_busy;
    logic [REG_ADDRW-1:0] i_rs2id;
    logic [CPU_WIDTH-1:0] o_rs2;
    logic                 o_rs2_busy;
    logic [REG_ADDRW-1:0] i_wbu_rdid;
    logic                 i_wbu_rdwen;
    logic [CPU_WIDTH-1:0] i_wbu_rd;
    logic                 o_sb_empty;
    logic                 o_sb_err;

    modport slave (
        input  i_flush, i_iss_valid, i_iss_rdid, i_iss_rdwen,
        input  i_rs1id, i_rs2id, i_wbu_rdid, i_wbu_rdwen, i_wbu_rd,
        output o_iss_ready, o_rs1, o_rs1_busy, o_rs2, o_rs2_busy,
        output o_sb_empty, o_sb_err
    );

    modport master (
        output i_flush, i_iss_valid, i_iss_rdid, i_iss_rdwen,
        output i_rs1id, i_rs2id, i_wbu_rdid, i_wbu_rdwen, i_wbu_rd,
        input  o_iss_ready, o_rs1, o_rs1_busy, o_rs2, o_rs2_busy,
        input  o_sb_empty, o_sb_err
    );
endinterface

// File: rtl/gpr_sb.sv
// gpr_sb: 2^REG_ADDRW x CPU_WIDTH integer register file with a per-register
// pending-write scoreboard.
//   i_clk, i_rst : clock, synchronous active-high reset (clears regs,
//                  counters and the sticky error flag)
//   bus (slave)  : issue claims, two bypassed combinational read ports with
//                  busy flags, writeback port, flush, empty/error status.
// x0 is hardwired to zero and never tracked by the scoreboard.
module gpr_sb #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5,
    parameter int CNTW      = 2
) (
    input  logic     i_clk,
    input  logic     i_rst,
    gpr_sb_if.slave  bus
);
    localparam int              NREG    = 1 << REG_ADDRW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [CPU_WIDTH-1:0] r_regs [NREG];
    logic [CNTW-1:0]      r_cnt  [NREG];
    logic                 r_err;

    logic [NREG-1:0] w_dec;
    logic [NREG-1:0] w_inc;
    logic            w_sat;
    logic            w_ready;
    logic            w_any_pending;
    logic            w_rs1_byp;
    logic            w_rs2_byp;

    // Per-register release (writeback) and claim (accepted issue) strobes.
    always_comb begin
        w_dec = '0;
        w_inc = '0;
        for (int i = 1; i < NREG; i++) begin
            w_dec[i] = bus.i_wbu_rdwen && (bus.i_wbu_rdid == REG_ADDRW'(i));
            w_inc[i] = bus.i_iss_valid && w_ready && bus.i_iss_rdwen &&
                       (bus.i_iss_rdid == REG_ADDRW'(i));
        end
    end

    // A full counter can still take a claim when a release lands in the
    // same cycle, since the net count does not change.
    assign w_sat   = bus.i_iss_rdwen && (bus.i_iss_rdid != '0) &&
                     (r_cnt[bus.i_iss_rdid] == CNT_MAX) && !w_dec[bus.i_iss_rdid];
    assign w_ready = !bus.i_flush && !w_sat;
    assign bus.o_iss_ready = w_ready;

    // Read ports: x0 reads zero, a same-cycle writeback is forwarded.
    assign w_rs1_byp = bus.i_wbu_rdwen && (bus.i_wbu_rdid == bus.i_rs1id);
    assign w_rs2_byp = bus.i_wbu_rdwen && (bus.i_wbu_rdid == bus.i_rs2id);

    assign bus.o_rs1 = (bus.i_rs1id == '0) ? '0 :
                       w_rs1_byp ? bus.i_wbu_rd : r_regs[bus.i_rs1id];
    assign bus.o_rs2 = (bus.i_rs2id == '0) ? '0 :
                       w_rs2_byp ? bus.i_wbu_rd : r_regs[bus.i_rs2id];

    // Busy unless the only outstanding write is the one landing now.
    assign bus.o_rs1_busy = (bus.i_rs1id != '0) &&
                            (r_cnt[bus.i_rs1id] != CNTW'(w_rs1_byp));
    assign bus.o_rs2_busy = (bus.i_rs2id != '0) &&
                            (r_cnt[bus.i_rs2id] != CNTW'(w_rs2_byp));

    always_comb begin
        w_any_pending = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            w_any_pending = w_any_pending | (r_cnt[i] != '0);
        end
    end

    assign bus.o_sb_empty = !w_any_pending;
    assign bus.o_sb_err   = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_err <= 1'b0;
        end else begin
            // Writeback lands even in a flush cycle; only claims are killed.
            if (bus.i_wbu_rdwen && (bus.i_wbu_rdid != '0)) begin
                r_regs[bus.i_wbu_rdid] <= bus.i_wbu_rd;
            end
            for (int i = 1; i < NREG; i++) begin
                if (bus.i_flush) begin
                    r_cnt[i] <= '0;
                end else if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    // Release without a matching claim: hold at zero, flag it.
                    if (r_cnt[i] == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] - 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gpr_sb.sv
module tb_gpr_sb;
    localparam int CPU_WIDTH = 64;
    localparam int REG_ADDRW = 5;
    localparam int CNTW      = 2;
    localparam int NREG      = 32;
    localparam int CMAX      = 3;

    logic clk;
    logic rst;

    gpr_sb_if #(.CPU_WIDTH(CPU_WIDTH), .REG_ADDRW(REG_ADDRW)) bus ();

    gpr_sb #(.CPU_WIDTH(CPU_WIDTH), .REG_ADDRW(REG_ADDRW), .CNTW(CNTW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: architectural register values, outstanding write
    // count per register, sticky error.
    logic [63:0] m_reg [NREG];
    int          m_cnt [NREG];
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_empty();
        for (int i = 0; i < NREG; i++) if (m_cnt[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic drive_idle();
        bus.i_flush     = 1'b0;
        bus.i_iss_valid = 1'b0;
        bus.i_iss_rdid  = '0;
        bus.i_iss_rdwen = 1'b0;
        bus.i_rs1id     = '0;
        bus.i_rs2id     = '0;
        bus.i_wbu_rdid  = '0;
        bus.i_wbu_rdwen = 1'b0;
        bus.i_wbu_rd    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive, check every output against the model, then advance
    // the model with the spec's update rules.
    task automatic cyc(input bit fl, input bit iv, input int ird, input bit irw,
                       input int r1, input int r2,
                       input bit wen, input int wid, input logic [63:0] wd);
        bit          e_ready;
        bit          inc;
        bit          dec;
        int          nc;
        logic [63:0] e_rs1, e_rs2;
        bit          e_b1, e_b2;
        int          d1, d2;
        @(negedge clk);
        bus.i_flush     = fl;
        bus.i_iss_valid = iv;
        bus.i_iss_rdid  = ird[4:0];
        bus.i_iss_rdwen = irw;
        bus.i_rs1id     = r1[4:0];
        bus.i_rs2id     = r2[4:0];
        bus.i_wbu_rdwen = wen;
        bus.i_wbu_rdid  = wid[4:0];
        bus.i_wbu_rd    = wd;
        #1;
        e_ready = !fl && !(irw && ird != 0 && m_cnt[ird] == CMAX && !(wen && wid == ird));
        d1 = (wen && wid == r1) ? 1 : 0;
        d2 = (wen && wid == r2) ? 1 : 0;
        e_rs1 = (r1 == 0) ? 64'd0 : (d1 == 1) ? wd : m_reg[r1];
        e_rs2 = (r2 == 0) ? 64'd0 : (d2 == 1) ? wd : m_reg[r2];
        e_b1  = (r1 != 0) && (m_cnt[r1] - d1 != 0);
        e_b2  = (r2 != 0) && (m_cnt[r2] - d2 != 0);
        chk("iss_ready", {63'd0, bus.o_iss_ready}, {63'd0, e_ready});
        chk("rs1",       bus.o_rs1, e_rs1);
        chk("rs2",       bus.o_rs2, e_rs2);
        chk("rs1_busy",  {63'd0, bus.o_rs1_busy}, {63'd0, e_b1});
        chk("rs2_busy",  {63'd0, bus.o_rs2_busy}, {63'd0, e_b2});
        chk("sb_empty",  {63'd0, bus.o_sb_empty}, {63'd0, m_empty()});
        chk("sb_err",    {63'd0, bus.o_sb_err},   {63'd0, m_err});
        @(posedge clk);
        if (wen && wid != 0) m_reg[wid] = wd;
        if (fl) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        end else begin
            inc = iv && e_ready && irw && ird != 0;
            dec = wen && wid != 0;
            for (int i = 1; i < NREG; i++) begin
                nc = m_cnt[i] + ((inc && ird == i) ? 1 : 0) - ((dec && wid == i) ? 1 : 0);
                if (nc < 0) begin
                    m_err = 1'b1;
                    nc    = 0;
                end
                m_cnt[i] = nc;
            end
        end
    endtask

    task automatic idle(input int r1, input int r2);
        cyc(0, 0, 0, 0, r1, r2, 0, 0, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        do_reset();

        // Post-reset reads and status.
        idle(5, 0);

        // Claim r3, four cycles later its write lands with same-cycle bypass.
        cyc(0, 1, 3, 1, 3, 0, 0, 0, 64'd0);
        idle(3, 0);
        idle(3, 3);
        idle(0, 3);
        cyc(0, 0, 0, 0, 3, 0, 1, 3, 64'hDEAD_BEEF);
        idle(3, 3);

        // Saturate r7, then the coincident-release exception.
        cyc(0, 1, 7, 1, 7, 0, 0, 0, 64'd0);
        cyc(0, 1, 7, 1, 7, 0, 0, 0, 64'd0);
        cyc(0, 1, 7, 1, 7, 0, 0, 0, 64'd0);
        cyc(0, 1, 7, 1, 7, 0, 0, 0, 64'd0);
        cyc(0, 1, 7, 1, 7, 0, 1, 7, 64'h77);
        cyc(0, 0, 0, 0, 7, 0, 1, 7, 64'h78);
        cyc(0, 0, 0, 0, 7, 0, 1, 7, 64'h79);
        cyc(0, 0, 0, 0, 7, 7, 1, 7, 64'h7A);
        idle(7, 0);

        // x0 is neither written nor tracked.
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 64'h55);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 64'd0);
        idle(0, 0);

        // Flush with a coincident writeback.
        cyc(0, 1, 4, 1, 0, 0, 0, 0, 64'd0);
        cyc(0, 1, 4, 1, 0, 0, 0, 0, 64'd0);
        cyc(0, 1, 9, 1, 4, 9, 0, 0, 64'd0);
        cyc(1, 1, 9, 1, 4, 9, 1, 4, 64'h10);
        idle(4, 9);

        // Release on an unclaimed register: sticky through flush, reset clears.
        cyc(0, 0, 0, 0, 12, 0, 1, 12, 64'hC0);
        idle(12, 0);
        cyc(1, 0, 0, 0, 12, 0, 0, 0, 64'd0);
        idle(12, 0);
        do_reset();
        idle(12, 4);

        // Random traffic: releases only target claimed registers (or x0),
        // so the error flag must stay clear.
        for (int n = 0; n < 600; n++) begin
            bit          fl, iv, irw, wen;
            int          ird, r1, r2, wid, start;
            logic [63:0] wd;
            fl  = ($urandom_range(0, 24) == 0);
            iv  = $urandom_range(0, 1);
            irw = ($urandom_range(0, 3) != 0);
            ird = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            r1  = ($urandom_range(0, 1) == 0) ? ird : $urandom_range(0, 7);
            r2  = $urandom_range(0, 31);
            wd  = {$urandom, $urandom};
            wen = 1'b0;
            wid = 0;
            if ($urandom_range(0, 2) != 0) begin
                start = $urandom_range(0, 31);
                for (int k = 0; k < NREG; k++) begin
                    int j;
                    j = (start + k) % NREG;
                    if (!wen && j != 0 && m_cnt[j] > 0) begin
                        wen = 1'b1;
                        wid = j;
                    end
                end
                if (!wen && $urandom_range(0, 3) == 0) wen = 1'b1;
            end
            if ($urandom_range(0, 1) == 0 && wen) r2 = wid;
            cyc(fl, iv, ird, irw, r1, r2, wen, wid, wd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
